// File: rtl/adder_arbiter.sv
// Round-robin sequencer that time-shares one registered 4-bit adder among NREQ
// requesters and returns each 5-bit sum tagged with the owning requester index.
module adder_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] a_in,
  input  logic [4*NREQ-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  input  logic [4:0]        add_sum,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [4:0]        rsp_sum,
  output logic              busy
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [IDW-1:0]  cur_id, cur_id_d;
  logic [NREQ-1:0] gnt_d;
  logic [3:0]      add_a_d, add_b_d;
  logic            rsp_valid_d;
  logic [IDW-1:0]  rsp_id_d;
  logic [4:0]      rsp_sum_d;
  logic [IDW:0]    pick;
  logic [IDW-1:0]  win;
  logic [3:0]      a_sel, b_sel;

  // Scan from the farthest candidate to the nearest so the nearest asserted
  // request (ptr+1 first) overwrites any earlier hit; MSB flags a winner.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                           input logic [IDW-1:0]  p);
    logic [IDW:0]   res;
    logic [IDW-1:0] sel;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      sel = IDW'((int'(p) + i) % NREQ);
      if (r[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  always_comb begin
    pick  = rr_pick(req, ptr);
    win   = pick[IDW-1:0];
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = a_in[4*i +: 4];
        b_sel = b_in[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ptr_d       = ptr;
    cur_id_d    = cur_id;
    gnt_d       = '0;
    add_a_d     = add_a;
    add_b_d     = add_b;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id;
    rsp_sum_d   = rsp_sum;
    case (state)
      S_IDLE, S_DONE: begin
        if (pick[IDW]) begin
          state_d  = S_ISSUE;
          cur_id_d = win;
          ptr_d    = win;
          add_a_d  = a_sel;
          add_b_d  = b_sel;
          for (int i = 0; i < NREQ; i++) gnt_d[i] = (win == IDW'(i));
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CW'(LAT - 1);
      end
      S_WAIT: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          // Adder output has settled; capture it with its owner's tag.
          state_d     = S_DONE;
          rsp_valid_d = 1'b1;
          rsp_sum_d   = add_sum;
          rsp_id_d    = cur_id;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= IDW'(NREQ - 1);
      cur_id    <= '0;
      gnt       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      ptr       <= ptr_d;
      cur_id    <= cur_id_d;
      gnt       <= gnt_d;
      add_a     <= add_a_d;
      add_b     <= add_b_d;
      rsp_valid <= rsp_valid_d;
      rsp_id    <= rsp_id_d;
      rsp_sum   <= rsp_sum_d;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: one LAT=1 instance with a response scoreboard and
// one LAT=3 instance for the long-latency sequence, each with its own adder model.
module tb_adder_arbiter;
  localparam int NREQ = 4;
  localparam int LAT1 = 1;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  req, gnt, add_a, add_b;
  logic [15:0] a_in, b_in;
  logic [4:0]  add_sum, rsp_sum;
  logic        rsp_valid, busy;
  logic [1:0]  rsp_id;

  logic [3:0]  req3, gnt3, add_a3, add_b3;
  logic [15:0] a_in3, b_in3;
  logic [4:0]  add_sum3, rsp_sum3;
  logic        rsp_valid3, busy3;
  logic [1:0]  rsp_id3;

  adder_arbiter #(.NREQ(NREQ), .LAT(LAT1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy));

  adder_arbiter #(.NREQ(NREQ), .LAT(LAT3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .a_in(a_in3), .b_in(b_in3), .gnt(gnt3),
    .add_a(add_a3), .add_b(add_b3), .add_sum(add_sum3), .rsp_valid(rsp_valid3),
    .rsp_id(rsp_id3), .rsp_sum(rsp_sum3), .busy(busy3));

  // Registered adders with the matching latencies.
  logic [4:0] pipe1;
  logic [4:0] pipe3 [3];
  always @(posedge clk) begin
    pipe1    <= {1'b0, add_a} + {1'b0, add_b};
    pipe3[0] <= {1'b0, add_a3} + {1'b0, add_b3};
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign add_sum  = pipe1;
  assign add_sum3 = pipe3[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [1:0] id;
    logic [4:0] sum;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("rsp_gnt_overlap", int'(gnt), 0);
      if (sbq.size() == 0) begin
        check("rsp_with_nothing_pending", int'(rsp_valid), 0);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_id", int'(rsp_id), int'(mon_e.id));
        check("rsp_sum", int'(rsp_sum), int'(mon_e.sum));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int id, input int sum);
    exp_t e;
    e.id  = 2'(id);
    e.sum = 5'(sum);
    sbq.push_back(e);
  endtask

  // Single request on the LAT=1 instance; caller is just after a posedge.
  task automatic do_single(input int id, input logic [3:0] a, input logic [3:0] b,
                           input int exp_sum, input string tag);
    bit got, done;
    int gc, busy_n, rv_lat;
    a_in = '0;
    b_in = '0;
    a_in[4*id +: 4] = a;
    b_in[4*id +: 4] = b;
    req = 4'(1 << id);
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (gnt != '0) got = 1;
    end
    check({tag, "_gnt"}, int'(gnt), 1 << id);
    gc = cyc;
    busy_n = busy ? 1 : 0;
    if (got) push_exp(id, exp_sum);
    tick();
    req  = '0;
    a_in = ~a_in;
    b_in = ~b_in;
    rv_lat = -1;
    done = 0;
    for (int t = 0; t < 12 && !done; t++) begin
      @(negedge clk);
      if (rsp_valid) rv_lat = cyc - gc;
      if (busy) busy_n++;
      else done = 1;
    end
    check({tag, "_busy_span"}, busy_n, LAT1 + 2);
    check({tag, "_rsp_latency"}, rv_lat, LAT1 + 1);
    tick();
  endtask

  typedef struct {
    int         id;
    logic [3:0] a;
    logic [3:0] b;
    int         sum;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int prev, gc, lat, nrv, ng1, got_sum, got_id;
    bit got, done;

    vecs[0] = '{id: 2, a: 4'd3,  b: 4'd5,  sum: 8};
    vecs[1] = '{id: 1, a: 4'd15, b: 4'd15, sum: 30};
    vecs[2] = '{id: 0, a: 4'd0,  b: 4'd0,  sum: 0};
    vecs[3] = '{id: 3, a: 4'd7,  b: 4'd9,  sum: 16};
    vecs[4] = '{id: 0, a: 4'd9,  b: 4'd6,  sum: 15};
    vecs[5] = '{id: 1, a: 4'd8,  b: 4'd12, sum: 20};

    rst_n = 1'b0;
    req = '0;  a_in = '0;  b_in = '0;
    req3 = '0; a_in3 = '0; b_in3 = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_add_a", int'(add_a), 0);
    check("rst_add_b", int'(add_b), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_sum", int'(rsp_sum), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_busy3", int'(busy3), 0);
    rst_n = 1'b1;
    tick();

    // All four requesting continuously: rotation 0,1,2,3,0 every LAT+2 cycles.
    for (int i = 0; i < NREQ; i++) begin
      a_in[4*i +: 4] = 4'(i);
      b_in[4*i +: 4] = 4'(i + 1);
    end
    req = 4'hF;
    prev = -1;
    for (int n = 0; n < 5; n++) begin
      got = 0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge clk);
        if (gnt != '0) got = 1;
      end
      check("b2b_gnt", int'(gnt), 1 << (n % NREQ));
      if (prev >= 0) check("b2b_spacing", cyc - prev, LAT1 + 2);
      prev = cyc;
      if (got) push_exp(n % NREQ, 2 * (n % NREQ) + 1);
    end
    tick();
    req = '0;
    done = 0;
    for (int t = 0; t < 10 && !done; t++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    check("b2b_drain_idle", int'(busy), 0);
    tick();

    for (int i = 0; i < 6; i++)
      do_single(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));

    // Reset asserted while the operation sits in WAIT.
    a_in = '0; b_in = '0;
    a_in[11:8] = 4'd4;
    b_in[11:8] = 4'd4;
    req = 4'b0100;
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (gnt != '0) got = 1;
    end
    check("rstwait_gnt", int'(gnt), 4);
    tick();
    req = '0;
    check("rstwait_busy_before", int'(busy), 1);
    check("rstwait_add_a_before", int'(add_a), 4);
    rst_n = 1'b0;
    #1;
    check("rstwait_gnt0", int'(gnt), 0);
    check("rstwait_add_a0", int'(add_a), 0);
    check("rstwait_add_b0", int'(add_b), 0);
    check("rstwait_rsp_valid0", int'(rsp_valid), 0);
    check("rstwait_rsp_id0", int'(rsp_id), 0);
    check("rstwait_rsp_sum0", int'(rsp_sum), 0);
    check("rstwait_busy0", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nrv = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (rsp_valid) nrv++;
    end
    check("rstwait_no_rsp", nrv, 0);
    tick();
    do_single(3, 4'd6, 4'd7, 13, "post_rst");

    // req[1] pulsed for one IDLE cycle while req[0] wins (ptr is 3 here).
    a_in = '0; b_in = '0;
    a_in[3:0] = 4'd2;  b_in[3:0] = 4'd9;
    a_in[7:4] = 4'd5;  b_in[7:4] = 4'd5;
    req = 4'b0011;
    tick();
    req = '0;
    @(negedge clk);
    check("pulse_gnt", int'(gnt), 1);
    if (gnt == 4'b0001) push_exp(0, 11);
    ng1 = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (gnt[1]) ng1++;
    end
    check("pulse_no_gnt1", ng1, 0);
    tick();

    // LAT=3 instance: req[0] a=9 b=6.
    a_in3[3:0] = 4'd9;
    b_in3[3:0] = 4'd6;
    req3 = 4'b0001;
    got = 0;
    for (int t = 0; t < 8 && !got; t++) begin
      @(negedge clk);
      if (gnt3 != '0) got = 1;
    end
    check("lat3_gnt", int'(gnt3), 1);
    gc = cyc;
    tick();
    req3 = '0;
    a_in3 = '0;
    b_in3 = '0;
    lat = -1; got_sum = -1; got_id = -1;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (cyc - gc <= LAT3) begin
        check("lat3_add_a_stable", int'(add_a3), 9);
        check("lat3_add_b_stable", int'(add_b3), 6);
      end
      if (rsp_valid3) begin
        lat = cyc - gc;
        got_sum = int'(rsp_sum3);
        got_id = int'(rsp_id3);
      end
    end
    check("lat3_rsp_latency", lat, LAT3 + 1);
    check("lat3_rsp_sum", got_sum, 15);
    check("lat3_rsp_id", got_id, 0);

    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
